ram_arb_ctrl: RTL and testbench
===============================

# ram_arb_ctrl

Two-requester controller for the 8-entry × 8-bit single-port RAM. It clears the RAM after reset or on command, then shares the single port between two requesters using round-robin arbitration. Read data is returned with a registered valid strobe. The block sits between the two client blocks and the RAM instance, and drives every RAM control pin.

## Interface
Parameters:
- DATA_W, 8, word width
- ADDR_W, 3, address width; depth = 2**ADDR_W

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- clr  in  1  single-cycle request to re-clear the RAM
- busy  out  1  high while in CLEAR
- req0 / req1  in  1  access request; held until granted
- we0 / we1  in  1  1 = write, 0 = read; qualified by reqN
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  combinational grant; the access executes on this edge
- rvalid0 / rvalid1  out  1  registered; read data valid for that port
- rdata  out  DATA_W  shared read data; meaningful only while rvalid0 or rvalid1 is high
- ram_en  out  1  RAM enable
- ram_wr  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_dout  in  DATA_W  RAM read data; registered by the RAM on an edge with en=1 and wr=0

## Operation
- **States:** CLEAR, SERVE.
- **Reset:**
  - State values: state=CLEAR, clear counter cnt=0, priority pointer prio=0, rvalid0=rvalid1=0.
  - While rst=1, gnt0, gnt1, ram_en and ram_wr are forced to 0.
  - busy=1 from the first post-reset cycle.
- **CLEAR:**
  - Drives ram_en=1, ram_wr=1, ram_addr=cnt, ram_din=0; cnt increments each cycle.
  - Leaves for SERVE on the cycle cnt = depth-1, after that write completes. Total duration is exactly depth cycles.
  - gnt0=gnt1=0 throughout. clr is ignored.
- **SERVE, clr=1:** no grant that cycle, ram_en=0; next state is CLEAR with cnt=0.
- **SERVE, clr=0, arbitration:**
  - Only req0 high → gnt0.
  - Only req1 high → gnt1.
  - Both high → the port equal to prio is granted.
  - Neither high → ram_en=0.
- **Granted port drives the RAM:** ram_en=1, ram_wr=weN, ram_addr=addrN, ram_din=wdataN.
- **Priority pointer:** after any grant, prio becomes the non-granted port. It is unchanged on idle cycles.
- **Read return:**
  - A granted read sets rvalidN=1 on the following cycle; rdata=ram_dout in that cycle.
  - Writes never raise rvalid. rvalid0 and rvalid1 are never high together.
- **Back-to-back accesses:** full throughput, one access per cycle. A read grant in cycle k and another grant in cycle k+1 are both legal.
- **Reset mid-operation:** aborts any clear or pending read. No rvalid is issued for a read granted in the cycle rst is asserted. Clearing restarts at address 0.

## Timing
- Grant latency: 0 cycles; gnt is a combinational function of reqN, state, clr and prio.
- Read latency: 1 cycle from the grant edge to rvalid/rdata.
- Write: committed on the grant edge.
- Clear: depth cycles, with busy high for exactly those cycles. The first SERVE cycle may grant.
- All registered outputs update only on the rising edge of clk.

## Structure
- **Package ram_arb_pkg:**
  - Localparams DATA_W_DEF=8 and ADDR_W_DEF=3.
  - State enum {CLEAR, SERVE}.
  - Port-index constants P0=0, P1=1.
- **Sub-module rr_arb2:**
  - Inputs: req[1:0], prio, en. Output: one-hot gnt[1:0].
  - Purely combinational.
  - The pointer register stays in the top level.
- **Bench:** instantiates the RAM model together with ram_arb_ctrl.

## Test plan
- **Reset/clear:** rst for 2 cycles, then release → busy high for exactly 8 cycles; ram_wr=1 with addresses 0..7 and din=0; then busy=0.
- **Single-port write/read:**
  - Port 0 writes 0xAA@0 and 0xF0@1, then reads @0 and @1.
  - Required: rvalid0 one cycle after each read grant, with rdata=0xAA then 0xF0. rvalid1 stays 0 throughout.
- **Contention round-robin:**
  - req0 and req1 both held high for 4 cycles, all writes.
  - Required: grant sequence 0,1,0,1 starting from prio=0. Each port's data lands at its own address.
- **Simultaneous reads:**
  - Port 0 reads @2 (0xCC) and port 1 reads @3 (0x33), both requesting in the same cycle.
  - Required: rvalid0 with rdata=0xCC, then rvalid1 with rdata=0x33 on the next cycle.
- **clr while requesting:**
  - Pulse clr with req1 high.
  - Required: no gnt1 that cycle; busy for 8 cycles; afterwards every read of 0..7 returns 0x00. gnt1 is issued on the first SERVE cycle.
- **Reset mid-clear and mid-read:**
  - Assert rst at clear cycle 4 → clear restarts at address 0 and runs a full 8 cycles.
  - Assert rst in a read-grant cycle → no rvalid follows.

Source files
------------

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and constants for the two-port RAM arbiter/clear
// controller.
//   DATA_W_DEF / ADDR_W_DEF : default word and address widths
//   state_e                 : controller states (CLEAR, SERVE)
//   P0 / P1                 : requester port indices
package ram_arb_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;

    typedef enum logic {
        CLEAR = 1'b0,
        SERVE = 1'b1
    } state_e;

    localparam logic P0 = 1'b0;
    localparam logic P1 = 1'b1;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin arbiter.
//   req  [1:0] : request per port
//   prio       : port that wins when both request
//   en         : grant enable; no grant when low
//   gnt  [1:0] : one-hot grant (all-zero when idle or disabled)
// The priority pointer is owned by the caller.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       prio,
    input  logic       en,
    output logic [1:0] gnt
);
    assign gnt[P0] = en & req[P0] & (~req[P1] | (prio == P0));
    assign gnt[P1] = en & req[P1] & (~req[P0] | (prio == P1));
endmodule

// File: rtl/ram_arb_ctrl.sv
// ram_arb_ctrl: clears an 8x8 single-port RAM after reset or on clr, then
// shares its port between two requesters with round-robin arbitration.
//   clk, rst (sync, active high), clr      : clock, reset, re-clear request
//   busy                                    : high while clearing
//   reqN/weN/addrN/wdataN, gntN             : requester N access, grant
//   rvalidN, rdata                          : read return (1 cycle after grant)
//   ram_en/ram_wr/ram_addr/ram_din/ram_dout : RAM port
module ram_arb_ctrl
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    output logic              busy,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              ram_en,
    output logic              ram_wr,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              prio_q;
    logic              rvalid0_q, rvalid1_q;

    logic              arb_en;
    logic              clearing;
    logic [1:0]        gnt;

    // Arbitration only in SERVE; a clr cycle or reset suppresses all grants.
    assign arb_en   = (state_q == SERVE) && !clr && !rst;
    assign clearing = (state_q == CLEAR) && !rst;

    rr_arb2 u_arb (
        .req  ({req1, req0}),
        .prio (prio_q),
        .en   (arb_en),
        .gnt  (gnt)
    );

    assign gnt0    = gnt[P0];
    assign gnt1    = gnt[P1];
    assign busy    = (state_q == CLEAR);
    assign rvalid0 = rvalid0_q;
    assign rvalid1 = rvalid1_q;
    // The RAM registers its output on the read edge, so it is already aligned
    // with the rvalid strobe.
    assign rdata   = ram_dout;

    always_comb begin
        ram_en   = 1'b0;
        ram_wr   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (clearing) begin
            ram_en   = 1'b1;
            ram_wr   = 1'b1;
            ram_addr = cnt_q;
        end else if (gnt[P0]) begin
            ram_en   = 1'b1;
            ram_wr   = we0;
            ram_addr = addr0;
            ram_din  = wdata0;
        end else if (gnt[P1]) begin
            ram_en   = 1'b1;
            ram_wr   = we1;
            ram_addr = addr1;
            ram_din  = wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= CLEAR;
            cnt_q     <= '0;
            prio_q    <= P0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= gnt[P0] & ~we0;
            rvalid1_q <= gnt[P1] & ~we1;

            // Loser of this cycle gets priority next; idle keeps the pointer.
            if (gnt[P0])      prio_q <= P1;
            else if (gnt[P1]) prio_q <= P0;

            case (state_q)
                CLEAR: begin
                    // Counter wraps to 0 on the last address, ready for the
                    // next clear.
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) state_q <= SERVE;
                end
                SERVE: begin
                    if (clr) begin
                        state_q <= CLEAR;
                        cnt_q   <= '0;
                    end
                end
                default: state_q <= CLEAR;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_arb_ctrl.sv
module tb_ram_arb_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1, clr = 1'b0;
    logic       req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [2:0] addr0 = '0, addr1 = '0;
    logic [7:0] wdata0 = '0, wdata1 = '0;
    logic       busy, gnt0, gnt1, rvalid0, rvalid1;
    logic [7:0] rdata;
    logic       ram_en, ram_wr;
    logic [2:0] ram_addr;
    logic [7:0] ram_din;
    logic [7:0] ram_dout = '0;
    logic [7:0] mem [8];

    int n_cmp = 0, n_err = 0;

    // Reference model state
    logic       m_known = 1'b0;
    int         m_left = 0;       // clear cycles still to run
    logic       m_prio = 1'b0;
    logic [7:0] m_mem [8];
    logic       m_rv0 = 1'b0, m_rv1 = 1'b0;
    logic [7:0] m_rdata = '0;
    int         last_g = -1;

    always #5 clk = ~clk;

    ram_arb_ctrl #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata(rdata), .ram_en(ram_en), .ram_wr(ram_wr), .ram_addr(ram_addr),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    // Single-port RAM: write or registered read on an enabled edge.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wr) mem[ram_addr] <= ram_din;
            else        ram_dout      <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check at negedge against the model,
    // then advance the model across the rising edge.
    task automatic cyc(input logic r, input logic c,
                       input logic q0, input logic w0, input logic [2:0] a0, input logic [7:0] d0,
                       input logic q1, input logic w1, input logic [2:0] a1, input logic [7:0] d1);
        int  g;
        int  idx;
        logic clearing;
        rst = r; clr = c;
        req0 = q0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = q1; we1 = w1; addr1 = a1; wdata1 = d1;
        @(negedge clk);
        clearing = m_known && (m_left > 0);
        g = -1;
        if (!r && m_known && !clearing && !c) begin
            if (q0 && q1) g = m_prio ? 1 : 0;
            else if (q0)  g = 0;
            else if (q1)  g = 1;
        end
        chk("gnt0", {31'd0, gnt0}, {31'd0, g == 0});
        chk("gnt1", {31'd0, gnt1}, {31'd0, g == 1});
        if (m_known) begin
            chk("busy", {31'd0, busy}, {31'd0, m_left > 0});
            chk("rvalid0", {31'd0, rvalid0}, {31'd0, m_rv0});
            chk("rvalid1", {31'd0, rvalid1}, {31'd0, m_rv1});
            if (m_rv0 || m_rv1) chk("rdata", {24'd0, rdata}, {24'd0, m_rdata});
        end
        if (r) begin
            chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
            chk("rst_ram_wr", {31'd0, ram_wr}, 32'd0);
        end else if (clearing) begin
            chk("clr_ram_en", {31'd0, ram_en}, 32'd1);
            chk("clr_ram_wr", {31'd0, ram_wr}, 32'd1);
            chk("clr_ram_addr", {29'd0, ram_addr}, 32'(8 - m_left));
            chk("clr_ram_din", {24'd0, ram_din}, 32'd0);
        end else if (g >= 0) begin
            chk("acc_ram_en", {31'd0, ram_en}, 32'd1);
            chk("acc_ram_wr", {31'd0, ram_wr}, {31'd0, (g == 0) ? w0 : w1});
            chk("acc_ram_addr", {29'd0, ram_addr}, {29'd0, (g == 0) ? a0 : a1});
            if ((g == 0) ? w0 : w1)
                chk("acc_ram_din", {24'd0, ram_din}, {24'd0, (g == 0) ? d0 : d1});
        end else begin
            chk("idle_ram_en", {31'd0, ram_en}, 32'd0);
        end
        last_g = g;
        @(posedge clk);
        if (r) begin
            m_known = 1'b1;
            m_left  = 8;
            m_prio  = 1'b0;
            m_rv0   = 1'b0;
            m_rv1   = 1'b0;
        end else begin
            m_rv0 = 1'b0;
            m_rv1 = 1'b0;
            if (m_left > 0) begin
                idx = 8 - m_left;
                m_mem[idx] = 8'h00;
                m_left--;
            end else if (c) begin
                m_left = 8;
            end else if (g == 0) begin
                if (w0) m_mem[a0] = d0;
                else begin m_rv0 = 1'b1; m_rdata = m_mem[a0]; end
                m_prio = 1'b1;
            end else if (g == 1) begin
                if (w1) m_mem[a1] = d1;
                else begin m_rv1 = 1'b1; m_rdata = m_mem[a1]; end
                m_prio = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
    endtask

    initial begin
        logic       pq0, pw0, pq1, pw1, r, c;
        logic [2:0] pa0, pa1;
        logic [7:0] pd0, pd1;

        @(posedge clk); #1;
        // Reset then full clear
        cyc(1, 0, 0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
        cyc(1, 0, 0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
        idle(10);

        // Port 0 writes and reads back
        cyc(0, 0, 1, 1, 3'd0, 8'hAA, 0, 0, 3'd0, 8'h00);
        cyc(0, 0, 1, 1, 3'd1, 8'hF0, 0, 0, 3'd0, 8'h00);
        cyc(0, 0, 1, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
        cyc(0, 0, 1, 0, 3'd1, 8'h00, 0, 0, 3'd0, 8'h00);
        idle(1);

        // Seed @2/@3, leaving prio at port 0
        cyc(0, 0, 1, 1, 3'd2, 8'hCC, 0, 0, 3'd0, 8'h00);
        cyc(0, 0, 0, 0, 3'd0, 8'h00, 1, 1, 3'd3, 8'h33);

        // Contention: both held for 4 cycles, all writes
        cyc(0, 0, 1, 1, 3'd4, 8'h41, 1, 1, 3'd5, 8'h51);
        cyc(0, 0, 1, 1, 3'd6, 8'h42, 1, 1, 3'd5, 8'h51);
        cyc(0, 0, 1, 1, 3'd6, 8'h42, 1, 1, 3'd7, 8'h52);
        cyc(0, 0, 1, 1, 3'd4, 8'h43, 1, 1, 3'd7, 8'h52);
        idle(1);

        // Simultaneous reads
        cyc(0, 0, 1, 0, 3'd2, 8'h00, 1, 0, 3'd3, 8'h00);
        cyc(0, 0, 0, 0, 3'd0, 8'h00, 1, 0, 3'd3, 8'h00);
        idle(1);

        // clr while port 1 requests; request held through the clear
        cyc(0, 1, 0, 0, 3'd0, 8'h00, 1, 0, 3'd5, 8'h00);
        for (int i = 0; i < 9; i++) cyc(0, 0, 0, 0, 3'd0, 8'h00, 1, 0, 3'd5, 8'h00);
        for (int i = 0; i < 8; i++) cyc(0, 0, 1, 0, 3'(i), 8'h00, 0, 0, 3'd0, 8'h00);
        idle(1);

        // Reset at clear cycle 4
        cyc(0, 0, 1, 1, 3'd6, 8'h77, 0, 0, 3'd0, 8'h00);
        cyc(0, 1, 0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
        idle(4);
        cyc(1, 0, 0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
        idle(9);

        // Reset in a cycle where a read would be granted
        cyc(1, 0, 1, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00);
        idle(10);

        // Randomized traffic with requests held until granted
        pq0 = 0; pq1 = 0; pw0 = 0; pw1 = 0; pa0 = '0; pa1 = '0; pd0 = '0; pd1 = '0;
        for (int i = 0; i < 500; i++) begin
            if (!pq0 && $urandom_range(0, 2) != 0) begin
                pq0 = 1; pw0 = 1'($urandom); pa0 = 3'($urandom); pd0 = 8'($urandom);
            end
            if (!pq1 && $urandom_range(0, 2) != 0) begin
                pq1 = 1; pw1 = 1'($urandom); pa1 = 3'($urandom); pd1 = 8'($urandom);
            end
            r = ($urandom_range(0, 149) == 0);
            c = ($urandom_range(0, 49) == 0);
            cyc(r, c, pq0, pw0, pa0, pd0, pq1, pw1, pa1, pd1);
            if (last_g == 0) pq0 = 0;
            if (last_g == 1) pq1 = 0;
        end
        idle(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
